tile_game_sequencer: RTL and testbench
======================================

# tile_game_sequencer

Game-flow controller for the five-lane falling-tile display. It runs on `pixel_clk` and synchronises the asynchronous vertical-sync strobe into a single-cycle frame tick. It judges each key press against the bottom-row tile and sequences the game through IDLE → PLAY → OVER. Each frame it hands the tile scroller a registered per-frame scroll step taken from a level-based speed schedule, so the scroller stays a pure datapath.

## Interface
Parameters:
- ROWS_PER_LEVEL, 5, cleared rows per speed-level increment
- MAX_LEVEL, 6, highest speed level (0-based)
- SCORE_W, 14, score counter width

Ports:
- pixel_clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- vs  in  1  vertical sync, asynchronous to pixel_clk, rising edge = new frame
- keycode  in  8  current USB keycode, 0 = no key
- row_advance  in  1  one-cycle pulse from scroller: bottom row has left the screen
- target_lane  in  3  lane 0..4 of the current bottom tile; 7 = no tile
- frame_tick  out  1  one-cycle pulse per frame
- scroll_step  out  4  pixels per frame for the scroller
- state  out  2  0 IDLE, 1 PLAY, 2 OVER
- level  out  3  current speed level
- score  out  SCORE_W  tiles hit
- hit_valid  out  1  one-cycle pulse on a correct hit
- hit_lane  out  3  lane of last correct hit
- game_over  out  1  high while in OVER

## Operation
- vs passes through a 2-flop synchroniser and a third edge-detect flop. frame_tick = sync_q & ~edge_q.
- Key press detect:
  - keycode is registered as key_q.
  - press = (keycode != 0) && (keycode != key_q).
  - Lane decode: 0x07→0 (D), 0x09→1 (F), 0x2C→2 (Space), 0x0D→3 (J), 0x0E→4 (K).
  - Unmapped codes are ignored in every state.
  - A held key generates exactly one press.
- armed flag: the bottom row is still unjudged.
- IDLE:
  - target_step = 0.
  - Any mapped press → PLAY. On entry score=0, level=0, rows_cnt=0, armed=1.
  - This entry press is not judged.
- PLAY:
  - target_step = speed table[level]: 1,2,4,6,8,10,12.
  - Mapped press while armed:
    - If lane == target_lane: score+1 (saturating at all-ones), hit_lane=lane, hit_valid pulse, armed=0.
    - Otherwise → OVER.
    - target_lane==7 counts as a mismatch.
  - Mapped press while not armed: ignored.
  - row_advance while armed and target_lane != 7: miss → OVER.
  - row_advance otherwise:
    - armed=1.
    - rows_cnt+1. When it reaches ROWS_PER_LEVEL: rows_cnt=0 and level+1, saturating at MAX_LEVEL.
- OVER:
  - target_step = 0, game_over=1.
  - A Space press (0x2C) → IDLE. score is held until the next IDLE→PLAY.
  - Other keys are ignored.
- Same-cycle press and row_advance: the press is judged first against the current target_lane, then row_advance is evaluated with the updated armed.
  - Correct hit + advance → no miss, rearm.
  - Wrong key + advance → OVER, and row_advance is discarded.
- scroll_step is loaded from target_step only on frame_tick, so it is constant within a frame.

## Timing
- Reset (async, any time):
  - state=IDLE, scroll_step=0, level=0, score=0.
  - frame_tick=0, hit_valid=0, hit_lane=0, game_over=0.
  - armed=1, rows_cnt=0, synchroniser and key_q cleared.
- frame_tick asserts 3 pixel_clk edges after a vs rising edge; one cycle wide.
- A press is recognised on the first edge where keycode differs from key_q. State, score and hit_valid update on that same edge.
- scroll_step changes at the first frame_tick after any state or level change. Latency ≤ 1 frame + 3 cycles.
- game_over is a combinational decode of registered state.
- row_advance must be a single-cycle pulse. Back-to-back pulses are each counted.

## Test plan
- Reset mid-PLAY with score=9, level=2 → next cycle state=0, score=0, level=0, scroll_step=0.
- IDLE, keycode 0x07, then vs pulse → state=1. At the first frame_tick scroll_step=1. score stays 0 (entry press unjudged).
- PLAY, target_lane=3, keycode 0x0D held 10 cycles → one hit_valid pulse, hit_lane=3, score=1. Then row_advance → armed again, no OVER.
- PLAY, target_lane=1, keycode 0x0E → state=2, game_over=1. At the next frame_tick scroll_step=0. Then keycode 0x2C → state=0.
- PLAY, 5 hit+row_advance cycles → level=1, scroll_step=2 after the next frame_tick. After 30 such rows, level saturates at 6 and scroll_step=12.
- Same cycle: correct key and row_advance → score+1, state stays PLAY. Armed, no press, row_advance with target_lane=2 → OVER. row_advance with target_lane=7 → stays PLAY.

Source files
------------

// File: rtl/tile_game_sequencer.sv
// Game-flow controller for the five-lane falling-tile display.
// Synchronises vsync, judges key presses, sequences IDLE/PLAY/OVER.
module tile_game_sequencer #(
    parameter int ROWS_PER_LEVEL = 5,
    parameter int MAX_LEVEL      = 6,
    parameter int SCORE_W        = 14
) (
    input  logic               pixel_clk,
    input  logic               Reset,
    input  logic               vs,
    input  logic [7:0]         keycode,
    input  logic               row_advance,
    input  logic [2:0]         target_lane,
    output logic               frame_tick,
    output logic [3:0]         scroll_step,
    output logic [1:0]         state,
    output logic [2:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic               hit_valid,
    output logic [2:0]         hit_lane,
    output logic               game_over
);

    localparam int RW = $clog2(ROWS_PER_LEVEL + 1);
    localparam logic [RW-1:0] ROWS_MAX = RW'(ROWS_PER_LEVEL);
    localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);
    localparam logic [2:0] NO_TILE = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t st_q, st_n;

    logic vs_s1, vs_s2, edge_q;
    logic [7:0] key_q;
    logic armed, armed_n;
    logic [RW-1:0] rows_cnt, rows_n;
    logic [2:0] level_n, hit_lane_n, lane;
    logic [SCORE_W-1:0] score_n;
    logic hit_valid_n, mapped, press;
    logic [3:0] target_step;

    always_comb begin
        mapped = 1'b1;
        lane   = 3'd0;
        case (keycode)
            8'h07:   lane = 3'd0;
            8'h09:   lane = 3'd1;
            8'h2C:   lane = 3'd2;
            8'h0D:   lane = 3'd3;
            8'h0E:   lane = 3'd4;
            default: mapped = 1'b0;
        endcase
    end

    assign press = (keycode != 8'h00) && (keycode != key_q);

    always_ff @(posedge pixel_clk or posedge Reset) begin
        if (Reset) begin
            vs_s1       <= 1'b0;
            vs_s2       <= 1'b0;
            edge_q      <= 1'b0;
            frame_tick  <= 1'b0;
            key_q       <= 8'h00;
            st_q        <= IDLE;
            score       <= '0;
            level       <= 3'd0;
            rows_cnt    <= '0;
            armed       <= 1'b1;
            hit_valid   <= 1'b0;
            hit_lane    <= 3'd0;
            scroll_step <= 4'd0;
        end else begin
            vs_s1      <= vs;
            vs_s2      <= vs_s1;
            edge_q     <= vs_s2;
            frame_tick <= vs_s2 & ~edge_q;
            key_q      <= keycode;
            st_q       <= st_n;
            score      <= score_n;
            level      <= level_n;
            rows_cnt   <= rows_n;
            armed      <= armed_n;
            hit_valid  <= hit_valid_n;
            hit_lane   <= hit_lane_n;
            if (frame_tick)
                scroll_step <= target_step;
        end
    end

    always_comb begin
        st_n        = st_q;
        score_n     = score;
        level_n     = level;
        rows_n      = rows_cnt;
        armed_n     = armed;
        hit_valid_n = 1'b0;
        hit_lane_n  = hit_lane;
        target_step = 4'd0;
        unique case (st_q)
            IDLE: begin
                if (press && mapped) begin
                    st_n    = PLAY;
                    score_n = '0;
                    level_n = 3'd0;
                    rows_n  = '0;
                    armed_n = 1'b1;
                end
            end
            PLAY: begin
                case (level)
                    3'd0:    target_step = 4'd1;
                    3'd1:    target_step = 4'd2;
                    3'd2:    target_step = 4'd4;
                    3'd3:    target_step = 4'd6;
                    3'd4:    target_step = 4'd8;
                    3'd5:    target_step = 4'd10;
                    default: target_step = 4'd12;
                endcase
                // Press is judged before row_advance sees the armed flag
                if (press && mapped && armed) begin
                    if (lane == target_lane) begin
                        if (score != '1)
                            score_n = score + SCORE_W'(1);
                        hit_lane_n  = lane;
                        hit_valid_n = 1'b1;
                        armed_n     = 1'b0;
                    end else begin
                        st_n = OVER;
                    end
                end
                if (row_advance && st_n == PLAY) begin
                    if (armed_n && target_lane != NO_TILE) begin
                        st_n = OVER;
                    end else begin
                        armed_n = 1'b1;
                        if (rows_cnt + RW'(1) == ROWS_MAX) begin
                            rows_n = '0;
                            if (level != LVL_MAX)
                                level_n = level + 3'd1;
                        end else begin
                            rows_n = rows_cnt + RW'(1);
                        end
                    end
                end
            end
            OVER: begin
                if (press && keycode == 8'h2C)
                    st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    assign state     = st_q;
    assign game_over = (st_q == OVER);

endmodule

// File: tb/tb_tile_game_sequencer.sv
// Directed self-checking bench for tile_game_sequencer.
module tb_tile_game_sequencer;

    logic        pixel_clk = 1'b0;
    logic        Reset;
    logic        vs;
    logic [7:0]  keycode;
    logic        row_advance;
    logic [2:0]  target_lane;
    logic        frame_tick;
    logic [3:0]  scroll_step;
    logic [1:0]  state;
    logic [2:0]  level;
    logic [13:0] score;
    logic        hit_valid;
    logic [2:0]  hit_lane;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_score;
    int rows;
    int pulses;
    logic [7:0] codes [5];

    tile_game_sequencer dut (
        .pixel_clk  (pixel_clk),
        .Reset      (Reset),
        .vs         (vs),
        .keycode    (keycode),
        .row_advance(row_advance),
        .target_lane(target_lane),
        .frame_tick (frame_tick),
        .scroll_step(scroll_step),
        .state      (state),
        .level      (level),
        .score      (score),
        .hit_valid  (hit_valid),
        .hit_lane   (hit_lane),
        .game_over  (game_over)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic press(logic [7:0] k);
        keycode = k;
        step(1);
        keycode = 8'h00;
        step(1);
    endtask

    task automatic frame();
        vs = 1'b1;
        step(2);
        check("ftick_early", frame_tick, 0);
        step(1);
        check("ftick", frame_tick, 1);
        step(1);
        check("ftick_width", frame_tick, 0);
        vs = 1'b0;
        step(4);
    endtask

    task automatic hit_row(int ln);
        target_lane = 3'(ln);
        keycode = codes[ln];
        step(1);
        keycode = 8'h00;
        row_advance = 1'b1;
        step(1);
        row_advance = 1'b0;
        step(1);
        exp_score++;
        rows++;
    endtask

    function automatic int exp_lvl(int r);
        return (r / 5 > 6) ? 6 : r / 5;
    endfunction

    initial begin
        codes = '{8'h07, 8'h09, 8'h2C, 8'h0D, 8'h0E};
        Reset = 1'b1;
        vs = 1'b0;
        keycode = 8'h00;
        row_advance = 1'b0;
        target_lane = 3'd7;
        step(2);
        Reset = 1'b0;
        step(1);
        check("rst_state", state, 0);
        check("rst_score", score, 0);
        check("rst_level", level, 0);
        check("rst_scroll", scroll_step, 0);
        check("rst_ftick", frame_tick, 0);
        check("rst_hitv", hit_valid, 0);
        check("rst_over", game_over, 0);

        press(8'h04);
        check("idle_unmapped", state, 0);
        press(8'h07);
        check("enter_play", state, 1);
        check("entry_unjudged", score, 0);
        frame();
        check("scroll_l0", scroll_step, 1);

        target_lane = 3'd3;
        keycode = 8'h0D;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (hit_valid) pulses++;
        end
        check("held_one_pulse", pulses, 1);
        check("hit_lane", hit_lane, 3);
        check("score_1", score, 1);
        keycode = 8'h00;
        row_advance = 1'b1;
        step(1);
        row_advance = 1'b0;
        step(1);
        check("adv_no_over", state, 1);
        exp_score = 1;
        rows = 1;
        press(8'h0D);
        exp_score++;
        check("rearmed_hit", score, 2);
        row_advance = 1'b1;
        step(1);
        row_advance = 1'b0;
        step(1);
        rows++;

        for (int i = 0; i < 3; i++) hit_row(i);
        check("level_1", level, 1);
        frame();
        check("scroll_l1", scroll_step, 2);
        for (int i = 0; i < 25; i++) hit_row(i % 5);
        check("level_6", level, exp_lvl(rows));
        frame();
        check("scroll_l6", scroll_step, 12);
        for (int i = 0; i < 5; i++) hit_row(4 - i);
        check("level_sat", level, 6);
        check("score_run", score, exp_score);

        target_lane = 3'd2;
        keycode = 8'h2C;
        row_advance = 1'b1;
        step(1);
        exp_score++;
        check("same_hitv", hit_valid, 1);
        check("same_score", score, exp_score);
        check("same_state", state, 1);
        keycode = 8'h00;
        row_advance = 1'b0;
        step(1);
        target_lane = 3'd7;
        row_advance = 1'b1;
        step(1);
        row_advance = 1'b0;
        check("notile_adv", state, 1);
        target_lane = 3'd2;
        row_advance = 1'b1;
        step(1);
        row_advance = 1'b0;
        check("miss_over", state, 2);
        check("miss_game_over", game_over, 1);
        frame();
        check("scroll_over", scroll_step, 0);
        press(8'h07);
        check("over_ignores", state, 2);
        press(8'h2C);
        check("over_to_idle", state, 0);
        check("score_held", score, exp_score);

        press(8'h09);
        check("replay", state, 1);
        check("replay_score", score, 0);
        check("replay_level", level, 0);
        frame();
        check("replay_scroll", scroll_step, 1);
        target_lane = 3'd1;
        press(8'h0E);
        check("wrong_over", state, 2);
        check("wrong_game_over", game_over, 1);
        press(8'h2C);
        press(8'h07);
        target_lane = 3'd1;
        keycode = 8'h07;
        row_advance = 1'b1;
        step(1);
        keycode = 8'h00;
        row_advance = 1'b0;
        step(1);
        check("wrong_adv_over", state, 2);
        check("wrong_adv_score", score, 0);

        press(8'h2C);
        press(8'h0D);
        exp_score = 0;
        rows = 0;
        for (int i = 0; i < 9; i++) hit_row(i % 5);
        target_lane = 3'd7;
        row_advance = 1'b1;
        step(1);
        row_advance = 1'b0;
        step(1);
        check("pre_rst_score", score, 9);
        check("pre_rst_level", level, 2);
        frame();
        check("scroll_l2", scroll_step, 4);
        #2 Reset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_score", score, 0);
        check("arst_level", level, 0);
        check("arst_scroll", scroll_step, 0);
        step(1);
        Reset = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
